spi_peripheral_mem: RTL and testbench
=====================================

Name: spi_peripheral_mem

Overview:
- SPI mode-0 responder: the far end of the SPI initiator block, serving the same address-byte/data-byte frame that block issues.
- Oversamples sclk, cs_n and mosi with the system clock, decodes one frame per cs_n assertion, and reads or writes an internal 128x8 byte memory.
- Drives miso with an explicit output enable so several responders can share the line.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on each of sclk/cs_n/mosi; minimum 2.
- MEM_DEPTH, 128, bytes of internal memory; fixed by the 7-bit address field.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from initiator, asynchronous to clk; idles low.
- cs_n  input  1  chip select, active low, asynchronous.
- mosi  input  1  serial data from initiator, MSB first.
- miso  output  1  serial data to initiator, MSB first.
- miso_oe  output  1  miso drive enable; 0 = miso is don't-care, line not driven.
- frame_done  output  1  one-clk pulse when a complete frame finishes.
- frame_err  output  1  one-clk pulse when cs_n deasserts mid-frame.

Behaviour:
- Conditioning:
  - Each input passes SYNC_STAGES flops, then one edge-detect flop.
  - Edge pulses (sclk_rise, sclk_fall, cs_fall, cs_rise) are valid SYNC_STAGES+1 clk cycles after the pin transition.
  - Sync flops reset to sclk=0, cs_n=1, mosi=0.
  - Each sclk phase must be held at least 4 clk cycles.
- Frame format:
  - Byte 0 (address byte): bit7 = R/W (1 = read), bits6:0 = address.
  - Byte 1 (data byte): write data in, or read data out.
- Sampling and shifting:
  - mosi is sampled on sclk_rise.
  - miso changes only on sclk_fall.
  - 3-bit bit counter; 8-bit shift register; 7-bit address latch; 1-bit rw latch.
- States:
  - IDLE: miso_oe=0. cs_fall -> ADDR; bit counter cleared.
  - ADDR: each sclk_rise shifts mosi in. On the 8th rise, latch address and rw. rw=0 -> WDATA; rw=1 -> RLOAD.
  - RLOAD, one clk: shift register <= mem[address] (synchronous read) -> RDATA.
  - RDATA:
    - 1st sclk_fall: miso_oe <= 1 and miso <= sr[7].
    - Each later sclk_fall: shift left and present the new sr[7].
    - Bit counter advances on sclk_rise; the 8th rise -> DONE, with frame_done pulsed that cycle.
  - WDATA: 8 sclk_rise shifts -> WCOMMIT.
  - WCOMMIT, one clk: mem[address] <= shift register; frame_done pulse -> DONE.
  - DONE: all sclk edges ignored; miso and miso_oe hold. cs_rise -> IDLE, miso_oe <= 0.
- cs_rise in ADDR, RLOAD, RDATA or WDATA: frame_err pulse, no memory write, miso_oe <= 0, -> IDLE. WCOMMIT always completes.
- cs_rise and sclk edge in the same clk cycle: cs_rise wins; the sclk edge is discarded.
- cs_fall while not IDLE cannot occur, because cs_rise is seen first.
- sclk edges while IDLE: ignored.
- Reset (asynchronous, any state, including mid-frame):
  - State IDLE; miso=0, miso_oe=0, frame_done=0, frame_err=0; counters, latches and shift register cleared.
  - Memory is not reset; contents are retained across reset.
- Bytes beyond 2 in one frame are ignored. There is no address auto-increment.

Test Plan:
- Write frame: cs_n low, shift 0x12 then 0x55, cs_n high -> exactly one frame_done, no frame_err, miso_oe stays 0 throughout.
- Read-back: frame 0x92 after the write -> miso_oe rises on the 1st data-phase sclk fall; miso bits sampled on rises = 0,1,0,1,0,1,0,1 (0x55); frame_done pulses once; miso_oe falls SYNC_STAGES+1 clk after cs_n rises.
- Address extremes: write 0xA5 to 0x7F and 0x3C to 0x00, then read both -> 0xA5 and 0x3C; neither write disturbs the other.
- Abort: cs_n high after 4 data bits of a write of 0xFF to 0x12 -> frame_err pulses once, no frame_done, subsequent read of 0x12 returns 0x55.
- Reset mid-read: assert reset during the RDATA 3rd bit -> miso_oe=0 and miso=0 immediately (asynchronous); after release, a fresh read of 0x12 returns 0x55.
- Extra clocks: 24 sclk pulses in one write frame to 0x20 with bytes 0x20, 0x11, 0x22 -> mem[0x20]=0x11, a single frame_done, no frame_err.

Source files
------------

// File: rtl/spi_peripheral_mem.sv
// SPI mode-0 responder with a 128x8 internal memory.
// Frame: address byte (bit7 = read), then one data byte. miso_oe gates the shared miso line.
module spi_peripheral_mem #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MEM_DEPTH   = 128
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    output logic frame_done,
    output logic frame_err
);

    localparam int unsigned AW = 7;
    localparam int unsigned CW = 3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_RLOAD   = 3'd2;
    localparam logic [2:0] ST_RDATA   = 3'd3;
    localparam logic [2:0] ST_WDATA   = 3'd4;
    localparam logic [2:0] ST_WCOMMIT = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_q, cs_q, mosi_q;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [2:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    sr, sr_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic          rw, rw_nxt;
    logic          miso_nxt, oe_nxt, done_nxt, err_nxt;
    logic          mem_we;

    logic [7:0] mem [MEM_DEPTH];

    // Input synchronizers plus one edge-detect flop per line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_q;
            cs_d      <= cs_q;
        end
    end

    assign sclk_q    = sclk_sync[SYNC_STAGES-1];
    assign cs_q      = cs_sync[SYNC_STAGES-1];
    assign mosi_q    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_q & ~sclk_d;
    assign sclk_fall = ~sclk_q & sclk_d;
    assign cs_rise   = cs_q & ~cs_d;
    assign cs_fall   = ~cs_q & cs_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sr         <= '0;
            addr       <= '0;
            rw         <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sr         <= sr_nxt;
            addr       <= addr_nxt;
            rw         <= rw_nxt;
            miso       <= miso_nxt;
            miso_oe    <= oe_nxt;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
        end
    end

    // Memory is deliberately left out of reset so contents survive it
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= sr;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        addr_nxt  = addr;
        rw_nxt    = rw;
        miso_nxt  = miso;
        oe_nxt    = miso_oe;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        mem_we    = 1'b0;

        // cs_rise overrides any same-cycle sclk edge; a pending commit still lands
        if (cs_rise && state != ST_IDLE && state != ST_WCOMMIT) begin
            state_nxt = ST_IDLE;
            oe_nxt    = 1'b0;
            err_nxt   = (state != ST_DONE);
        end else begin
            case (state)
                ST_IDLE: begin
                    oe_nxt = 1'b0;
                    if (cs_fall) begin
                        state_nxt = ST_ADDR;
                        cnt_nxt   = '0;
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        sr_nxt  = {sr[6:0], mosi_q};
                        cnt_nxt = CW'(cnt + CW'(1));
                        if (cnt == CW'(7)) begin
                            addr_nxt  = {sr[5:0], mosi_q};
                            rw_nxt    = sr[6];
                            state_nxt = sr[6] ? ST_RLOAD : ST_WDATA;
                        end
                    end
                end
                ST_RLOAD: begin
                    sr_nxt    = mem[addr];
                    state_nxt = ST_RDATA;
                end
                ST_RDATA: begin
                    if (sclk_fall) begin
                        if (!miso_oe) begin
                            oe_nxt   = 1'b1;
                            miso_nxt = sr[7];
                        end else begin
                            sr_nxt   = {sr[6:0], 1'b0};
                            miso_nxt = sr[6];
                        end
                    end
                    if (sclk_rise) begin
                        cnt_nxt = CW'(cnt + CW'(1));
                        if (cnt == CW'(7)) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        sr_nxt  = {sr[6:0], mosi_q};
                        cnt_nxt = CW'(cnt + CW'(1));
                        if (cnt == CW'(7)) state_nxt = ST_WCOMMIT;
                    end
                end
                ST_WCOMMIT: begin
                    mem_we    = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = cs_rise ? ST_IDLE : ST_DONE;
                end
                ST_DONE: ;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral_mem.sv
// Directed bench for spi_peripheral_mem: writes, read-backs, abort, reset and overlong frames.
module tb_spi_peripheral_mem;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int H = 6;

    logic clk = 1'b0;
    logic reset, sclk, cs_n, mosi;
    logic miso, miso_oe, frame_done, frame_err;

    int checks = 0;
    int fails  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic oe_seen = 1'b0;

    spi_peripheral_mem #(.SYNC_STAGES(SYNC_STAGES), .MEM_DEPTH(128)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
        if (miso_oe)    oe_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            wait_clk(H);
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            wait_clk(H);
            sclk = 1'b0;
        end
    endtask

    task automatic end_frame();
        wait_clk(H);
        cs_n = 1'b1;
        wait_clk(12);
    endtask

    task automatic write_frame(input logic [6:0] a, input logic [7:0] d);
        logic [7:0] rx;
        cs_n = 1'b0;
        wait_clk(H);
        spi_bits({1'b0, a}, 8, rx);
        spi_bits(d, 8, rx);
        end_frame();
    endtask

    task automatic read_frame(input logic [6:0] a, output logic [7:0] d);
        logic [7:0] rx;
        cs_n = 1'b0;
        wait_clk(H);
        spi_bits({1'b1, a}, 8, rx);
        spi_bits(8'h00, 8, d);
        end_frame();
    endtask

    initial begin
        logic [7:0] rx, rd;
        int d0, e0, lat;

        reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        wait_clk(3);
        check_eq("rst_miso", 32'(miso), 32'd0);
        check_eq("rst_oe", 32'(miso_oe), 32'd0);
        check_eq("rst_done", 32'(frame_done), 32'd0);
        check_eq("rst_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        wait_clk(5);

        // Write 0x55 to 0x12
        d0 = done_cnt; e0 = err_cnt; oe_seen = 1'b0;
        write_frame(7'h12, 8'h55);
        check_eq("wr_done", 32'(done_cnt - d0), 32'd1);
        check_eq("wr_err", 32'(err_cnt - e0), 32'd0);
        check_eq("wr_oe_low", 32'(oe_seen), 32'd0);

        // Detailed read-back of 0x12
        d0 = done_cnt; e0 = err_cnt;
        cs_n = 1'b0;
        wait_clk(H);
        spi_bits(8'h92, 7, rx);
        mosi = 1'b0;
        wait_clk(H);
        sclk = 1'b1;
        wait_clk(H);
        check_eq("rd_oe_before_fall", 32'(miso_oe), 32'd0);
        sclk = 1'b0;
        wait_clk(5);
        check_eq("rd_oe_after_fall", 32'(miso_oe), 32'd1);
        spi_bits(8'h00, 8, rx);
        check_eq("rd_data", 32'(rx), 32'h55);
        wait_clk(H);
        check_eq("rd_oe_hold_done", 32'(miso_oe), 32'd1);
        cs_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!miso_oe) begin lat = i; break; end
        end
        check_eq("rd_oe_fall_latency", 32'(lat), 32'(SYNC_STAGES + 1));
        wait_clk(10);
        check_eq("rd_done", 32'(done_cnt - d0), 32'd1);
        check_eq("rd_err", 32'(err_cnt - e0), 32'd0);

        // Address extremes
        write_frame(7'h7F, 8'hA5);
        write_frame(7'h00, 8'h3C);
        read_frame(7'h7F, rd);
        check_eq("rd_7f", 32'(rd), 32'hA5);
        read_frame(7'h00, rd);
        check_eq("rd_00", 32'(rd), 32'h3C);

        // Abort after 4 data bits of a write of 0xFF to 0x12
        d0 = done_cnt; e0 = err_cnt;
        cs_n = 1'b0;
        wait_clk(H);
        spi_bits(8'h12, 8, rx);
        spi_bits(8'hFF, 4, rx);
        end_frame();
        check_eq("abort_err", 32'(err_cnt - e0), 32'd1);
        check_eq("abort_done", 32'(done_cnt - d0), 32'd0);
        read_frame(7'h12, rd);
        check_eq("abort_rd_12", 32'(rd), 32'h55);

        // Asynchronous reset during the third read data bit
        cs_n = 1'b0;
        wait_clk(H);
        spi_bits(8'h92, 8, rx);
        spi_bits(8'h00, 2, rx);
        mosi = 1'b0;
        wait_clk(3);
        check_eq("mid_oe_pre", 32'(miso_oe), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_oe", 32'(miso_oe), 32'd0);
        check_eq("mid_rst_miso", 32'(miso), 32'd0);
        cs_n = 1'b1; sclk = 1'b0;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(5);
        read_frame(7'h12, rd);
        check_eq("post_rst_rd_12", 32'(rd), 32'h55);

        // 24 sclk pulses in one write frame; third byte ignored
        d0 = done_cnt; e0 = err_cnt;
        cs_n = 1'b0;
        wait_clk(H);
        spi_bits(8'h20, 8, rx);
        spi_bits(8'h11, 8, rx);
        spi_bits(8'h22, 8, rx);
        end_frame();
        check_eq("extra_done", 32'(done_cnt - d0), 32'd1);
        check_eq("extra_err", 32'(err_cnt - e0), 32'd0);
        read_frame(7'h20, rd);
        check_eq("extra_rd_20", 32'(rd), 32'h11);
        read_frame(7'h12, rd);
        check_eq("extra_rd_12", 32'(rd), 32'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
